adder_nbits_seq: RTL and testbench

- Parametrised multi-cycle adder/subtractor; successor to the combinational 4-bit adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, using a ripple carry held in a register between chunks.
- Start/busy/done handshake; result is registered and held until the next start.
- Used where a full-width single-cycle carry chain is too slow or too large.

---
 rtl/adder_nbits_seq.sv | 152 +++++++++++++++
 tb/tb_adder_nbits_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_nbits_seq.sv
// ---------------------------------------------------------------------------
// adder_nbits_seq
//   Multi-cycle WIDTH-bit adder/subtractor. It processes CHUNK bits per clock
//   and keeps the ripple carry in a register between chunks. Use it where a
//   full-width single-cycle carry chain is too slow or too large.
//
// Ports
//   i_w_clk    : clock, rising edge active
//   i_w_reset  : asynchronous, active-high reset
//   i_w_start  : request a new operation (sampled in IDLE or DONE only)
//   i_w_sub    : 0 = a + b + cin, 1 = a - b (latched at start)
//   i_w_cin    : carry-in for add mode (latched at start)
//   i_w_a/b    : WIDTH-bit operands (latched at start)
//   o_w_s      : WIDTH+1-bit result {carry, sum}; held until the next DONE
//   o_w_ovf    : two's-complement signed overflow of the result
//   o_w_busy   : high while chunks are being processed (RUN)
//   o_w_done   : one-cycle pulse in the cycle o_w_s/o_w_ovf take new values
// ---------------------------------------------------------------------------
module adder_nbits_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             i_w_clk,
    input  logic             i_w_reset,
    input  logic             i_w_start,
    input  logic             i_w_sub,
    input  logic             i_w_cin,
    input  logic [WIDTH-1:0] i_w_a,
    input  logic [WIDTH-1:0] i_w_b,
    output logic [WIDTH:0]   o_w_s,
    output logic             o_w_ovf,
    output logic             o_w_busy,
    output logic             o_w_done
);

    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;        // already inverted for subtract
    logic [WIDTH-1:0] r_sum;      // partial sum, filled one chunk per RUN cycle
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH:0]   r_s_hold;
    logic             r_ovf_hold;

    logic [CHUNK-1:0] w_a_ch_arr [NCH];
    logic [CHUNK-1:0] w_b_ch_arr [NCH];
    logic [CHUNK-1:0] w_a_ch;
    logic [CHUNK-1:0] w_b_ch;
    logic [CHUNK-1:0] w_ch_sum;
    logic             w_ch_cout;
    logic             w_last;
    logic             w_latch;
    logic [WIDTH:0]   w_s_new;
    logic             w_ovf_new;

    // Slice the latched operands into chunk-wide lanes.
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_slice
            assign w_a_ch_arr[gi] = r_a[gi*CHUNK +: CHUNK];
            assign w_b_ch_arr[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    // Select the lane addressed by the chunk index.
    always_comb begin
        w_a_ch = '0;
        w_b_ch = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_a_ch = w_a_ch_arr[i];
                w_b_ch = w_b_ch_arr[i];
            end
        end
    end

    assign {w_ch_cout, w_ch_sum} = {1'b0, w_a_ch} + {1'b0, w_b_ch} + {{CHUNK{1'b0}}, r_carry};

    assign w_last  = (r_idx == IDXW'(NCH - 1));
    assign w_latch = i_w_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // In DONE the carry register holds the final carry-out and r_sum is complete.
    // Overflow: operands of equal sign whose sum has the other sign.
    assign w_s_new   = {r_carry, r_sum};
    assign w_ovf_new = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (r_sum[WIDTH-1] != r_a[WIDTH-1]);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (i_w_start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: w_state_next = i_w_start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_w_clk or posedge i_w_reset) begin
        if (i_w_reset) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_carry    <= 1'b0;
            r_idx      <= '0;
            r_s_hold   <= '0;
            r_ovf_hold <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (r_state == ST_DONE) begin
                r_s_hold   <= w_s_new;
                r_ovf_hold <= w_ovf_new;
            end

            if (w_latch) begin
                // Subtract is a + ~b + 1; cin is ignored in that mode.
                r_a     <= i_w_a;
                r_b     <= i_w_sub ? ~i_w_b : i_w_b;
                r_carry <= i_w_sub | i_w_cin;
                r_idx   <= '0;
            end else if (r_state == ST_RUN) begin
                for (int i = 0; i < NCH; i++) begin
                    if (r_idx == IDXW'(i)) begin
                        r_sum[i*CHUNK +: CHUNK] <= w_ch_sum;
                    end
                end
                r_carry <= w_ch_cout;
                r_idx   <= r_idx + IDXW'(1);
            end
        end
    end

    assign o_w_busy = (r_state == ST_RUN);
    assign o_w_done = (r_state == ST_DONE);

    // The fresh result is shown during the DONE cycle itself so that it
    // coincides with the done pulse; afterwards the captured copy is held.
    assign o_w_s   = o_w_done ? w_s_new   : r_s_hold;
    assign o_w_ovf = o_w_done ? w_ovf_new : r_ovf_hold;

endmodule

// File: tb/tb_adder_nbits_seq.sv
// ---------------------------------------------------------------------------
// tb_adder_nbits_seq
//   Directed checks of the 16-bit/4-bit-chunk configuration, plus an
//   exhaustive sweep of three 4-bit configurations (CHUNK = 1, 2, 4) against
//   a signed/unsigned arithmetic reference.
// ---------------------------------------------------------------------------
module tb_adder_nbits_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start, sub, cin;
    logic [15:0] a, b;
    logic [16:0] s;
    logic        ovf, busy, done;

    adder_nbits_seq #(.WIDTH(16), .CHUNK(4)) dut (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start), .i_w_sub(sub),
        .i_w_cin(cin), .i_w_a(a), .i_w_b(b), .o_w_s(s), .o_w_ovf(ovf),
        .o_w_busy(busy), .o_w_done(done)
    );

    logic       sw_start, sw_sub, sw_cin;
    logic [3:0] sw_a, sw_b;
    logic [4:0] sw_s    [3];
    logic       sw_ovf  [3];
    logic       sw_busy [3];
    logic       sw_done [3];
    int         sw_nch  [3] = '{4, 2, 1};

    adder_nbits_seq #(.WIDTH(4), .CHUNK(1)) dut_c1 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(sw_start), .i_w_sub(sw_sub),
        .i_w_cin(sw_cin), .i_w_a(sw_a), .i_w_b(sw_b), .o_w_s(sw_s[0]),
        .o_w_ovf(sw_ovf[0]), .o_w_busy(sw_busy[0]), .o_w_done(sw_done[0])
    );
    adder_nbits_seq #(.WIDTH(4), .CHUNK(2)) dut_c2 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(sw_start), .i_w_sub(sw_sub),
        .i_w_cin(sw_cin), .i_w_a(sw_a), .i_w_b(sw_b), .o_w_s(sw_s[1]),
        .o_w_ovf(sw_ovf[1]), .o_w_busy(sw_busy[1]), .o_w_done(sw_done[1])
    );
    adder_nbits_seq #(.WIDTH(4), .CHUNK(4)) dut_c4 (
        .i_w_clk(clk), .i_w_reset(rst), .i_w_start(sw_start), .i_w_sub(sw_sub),
        .i_w_cin(sw_cin), .i_w_a(sw_a), .i_w_b(sw_b), .o_w_s(sw_s[2]),
        .o_w_ovf(sw_ovf[2]), .o_w_busy(sw_busy[2]), .o_w_done(sw_done[2])
    );

    int checks   = 0;
    int failures = 0;

    // Results of the most recent run_op call.
    bit          op_seen;
    int          op_lat;
    int          op_bcnt;
    bit          op_hold;
    logic [16:0] op_s;
    logic        op_ovf;

    // Issue one operation on the 16-bit DUT (caller is at posedge+1) and wait
    // for done. Latency counts cycles from the start cycle to the done cycle.
    // Returns in the done cycle.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tsub, input logic tcin);
        logic [16:0] prev;
        prev  = s;
        a     = ta;
        b     = tb_v;
        sub   = tsub;
        cin   = tcin;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble inputs: the latched operation must not notice.
        a = ~ta; b = ~tb_v; sub = ~tsub; cin = ~tcin;
        op_lat  = 1;
        op_bcnt = 0;
        op_hold = 1'b1;
        op_seen = 1'b0;
        while (!op_seen && op_lat < 40) begin
            if (done === 1'b1) begin
                op_seen = 1'b1;
            end else begin
                if (busy === 1'b1) op_bcnt++;
                if (s !== prev) op_hold = 1'b0;
                @(posedge clk); #1;
                op_lat++;
            end
        end
        op_s   = s;
        op_ovf = ovf;
        $display("op a=%h b=%h sub=%0d cin=%0d -> s=%h ovf=%0d lat=%0d busy=%0d",
                 ta, tb_v, tsub, tcin, op_s, op_ovf, op_lat, op_bcnt);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        checks++; if (s !== 17'h0)  begin failures++; $display("FAIL reset_s: got %h expected 00000", s); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
        idle_cycles(1);
        // 0x7000 + 0x1000 = 0x8000 with signed overflow.
        run_op(16'h7000, 16'h1000, 1'b0, 1'b0);
        checks++; if (op_s !== 17'h08000 || op_ovf !== 1'b1) begin
            failures++; $display("FAIL pre_async_reset: got s=%h ovf=%b expected s=08000 ovf=1", op_s, op_ovf);
        end
        // Assert reset mid-cycle inside the DONE cycle; outputs must clear at once.
        #2 rst = 1'b1;
        #1;
        $display("async reset mid-cycle: s=%h ovf=%b busy=%b done=%b", s, ovf, busy, done);
        checks++; if (s !== 17'h0)  begin failures++; $display("FAIL async_reset_s: got %h expected 00000", s); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL async_reset_ovf: got %b expected 0", ovf); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL async_reset_done: got %b expected 0", done); end
        #2 rst = 1'b0;
        idle_cycles(2);
    endtask

    task automatic test_add_carry();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        checks++; if (op_seen !== 1'b1 || op_lat != 5) begin failures++; $display("FAIL add_carry_latency: got %0d expected 5", op_lat); end
        checks++; if (op_bcnt != 4) begin failures++; $display("FAIL add_carry_busy_cycles: got %0d expected 4", op_bcnt); end
        checks++; if (op_s !== 17'h10000) begin failures++; $display("FAIL add_carry_s: got %h expected 10000", op_s); end
        checks++; if (op_ovf !== 1'b0) begin failures++; $display("FAIL add_carry_ovf: got %b expected 0", op_ovf); end
        idle_cycles(1);
        checks++; if (done !== 1'b0 || s !== 17'h10000) begin
            failures++; $display("FAIL add_carry_single_pulse: got done=%b s=%h expected done=0 s=10000", done, s);
        end
        // Carry-in: 0x1234 + 0x4321 + 1 = 0x5556.
        run_op(16'h1234, 16'h4321, 1'b0, 1'b1);
        checks++; if (op_s !== 17'h05556 || op_ovf !== 1'b0) begin
            failures++; $display("FAIL add_cin: got s=%h ovf=%b expected s=05556 ovf=0", op_s, op_ovf);
        end
        idle_cycles(2);
    endtask

    task automatic test_signed_ovf();
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        checks++; if (op_s !== 17'h08000 || op_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_add: got s=%h ovf=%b expected s=08000 ovf=1", op_s, op_ovf);
        end
        idle_cycles(1);
        // cin=0 here; subtract must still inject the +1.
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        checks++; if (op_s !== 17'h17FFF || op_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_sub: got s=%h ovf=%b expected s=17FFF ovf=1", op_s, op_ovf);
        end
        idle_cycles(1);
    endtask

    task automatic test_sub_borrow();
        // Previous result 0x17FFF must be held until done.
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1);
        checks++; if (op_s !== 17'h0FFFE || op_ovf !== 1'b0) begin
            failures++; $display("FAIL sub_borrow: got s=%h ovf=%b expected s=0FFFE ovf=0", op_s, op_ovf);
        end
        checks++; if (op_hold !== 1'b1) begin failures++; $display("FAIL sub_hold: got hold=%b expected 1", op_hold); end
        idle_cycles(2);
    endtask

    task automatic test_start_during_run();
        int  lat;
        bit  seen;
        bit  extra_done;
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        lat = 1; seen = 1'b0;
        while (!seen && lat < 40) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                start = 1'b0;
            end else begin
                // Hammer start with a different operation for every RUN cycle.
                start = busy;
                a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1;
                @(posedge clk); #1;
                lat++;
            end
        end
        $display("op a=1234 b=1111 with start pulses in RUN -> s=%h ovf=%0d lat=%0d", s, ovf, lat);
        checks++; if (lat != 5) begin failures++; $display("FAIL run_start_latency: got %0d expected 5", lat); end
        checks++; if (s !== 17'h02345 || ovf !== 1'b0) begin
            failures++; $display("FAIL run_start_result: got s=%h ovf=%b expected s=02345 ovf=0", s, ovf);
        end
        extra_done = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || done === 1'b1) extra_done = 1'b1;
        end
        checks++; if (extra_done !== 1'b0) begin failures++; $display("FAIL run_start_not_queued: got activity=%b expected 0", extra_done); end
    endtask

    task automatic test_back_to_back();
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        checks++; if (op_s !== 17'h01000 || op_ovf !== 1'b0) begin
            failures++; $display("FAIL b2b_first: got s=%h ovf=%b expected s=01000 ovf=0", op_s, op_ovf);
        end
        // Start raised in the DONE cycle.
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        checks++; if (op_lat != 5 || op_bcnt != 4) begin
            failures++; $display("FAIL b2b_latency: got lat=%0d busy=%0d expected lat=5 busy=4", op_lat, op_bcnt);
        end
        checks++; if (op_s !== 17'h10000 || op_ovf !== 1'b0) begin
            failures++; $display("FAIL b2b_second: got s=%h ovf=%b expected s=10000 ovf=0", op_s, op_ovf);
        end
        checks++; if (op_hold !== 1'b1) begin failures++; $display("FAIL b2b_hold: got hold=%b expected 1", op_hold); end
        idle_cycles(2);
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        // RUN cycle 2: reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        $display("reset in RUN cycle 2: s=%h busy=%b done=%b", s, busy, done);
        checks++; if (busy !== 1'b0 || s !== 17'h0) begin
            failures++; $display("FAIL midrun_reset_out: got busy=%b s=%h expected busy=0 s=00000", busy, s);
        end
        #2 rst = 1'b0;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin failures++; $display("FAIL midrun_no_done: got activity=%b expected 0", saw_done); end
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0);
        checks++; if (op_lat != 5 || op_s !== 17'h00007 || op_ovf !== 1'b0) begin
            failures++; $display("FAIL midrun_recover: got lat=%0d s=%h ovf=%b expected lat=5 s=00007 ovf=0", op_lat, op_s, op_ovf);
        end
        idle_cycles(2);
    endtask

    task automatic test_sweep();
        int          lat [3];
        logic [4:0]  got_s [3];
        logic        got_ovf [3];
        logic [4:0]  exp_s;
        logic        exp_ovf;
        int          sa, sb, sr, n;
        for (int vsub = 0; vsub < 2; vsub++) begin
            for (int vcin = 0; vcin < 2; vcin++) begin
                for (int va = 0; va < 16; va++) begin
                    for (int vb = 0; vb < 16; vb++) begin
                        sa = (va >= 8) ? va - 16 : va;
                        sb = (vb >= 8) ? vb - 16 : vb;
                        if (vsub == 1) begin
                            exp_s = {(va >= vb) ? 1'b1 : 1'b0, 4'((va - vb) & 15)};
                            sr    = sa - sb;
                        end else begin
                            exp_s = 5'(va + vb + vcin);
                            sr    = sa + sb + vcin;
                        end
                        exp_ovf = (sr > 7 || sr < -8) ? 1'b1 : 1'b0;

                        sw_a = 4'(va); sw_b = 4'(vb); sw_sub = vsub[0]; sw_cin = vcin[0];
                        sw_start = 1'b1;
                        @(posedge clk); #1;
                        sw_start = 1'b0;
                        sw_a = ~sw_a; sw_b = ~sw_b; sw_sub = ~sw_sub; sw_cin = ~sw_cin;
                        for (int d = 0; d < 3; d++) begin
                            lat[d] = 0; got_s[d] = 'x; got_ovf[d] = 1'bx;
                        end
                        n = 1;
                        while (n < 10 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0)) begin
                            for (int d = 0; d < 3; d++) begin
                                if (lat[d] == 0 && sw_done[d] === 1'b1) begin
                                    lat[d]     = n;
                                    got_s[d]   = sw_s[d];
                                    got_ovf[d] = sw_ovf[d];
                                end
                            end
                            if (lat[0] == 0 || lat[1] == 0 || lat[2] == 0) begin
                                @(posedge clk); #1;
                                n++;
                            end
                        end
                        $display("sweep a=%0d b=%0d sub=%0d cin=%0d exp=%h/%0d c1=%h/%0d/%0d c2=%h/%0d/%0d c4=%h/%0d/%0d",
                                 va, vb, vsub, vcin, exp_s, exp_ovf,
                                 got_s[0], got_ovf[0], lat[0], got_s[1], got_ovf[1], lat[1],
                                 got_s[2], got_ovf[2], lat[2]);
                        for (int d = 0; d < 3; d++) begin
                            checks++;
                            if (lat[d] != sw_nch[d] + 1) begin
                                failures++;
                                $display("FAIL sweep_latency nch=%0d a=%0d b=%0d sub=%0d cin=%0d: got %0d expected %0d",
                                         sw_nch[d], va, vb, vsub, vcin, lat[d], sw_nch[d] + 1);
                            end
                            checks++;
                            if (got_s[d] !== exp_s) begin
                                failures++;
                                $display("FAIL sweep_s nch=%0d a=%0d b=%0d sub=%0d cin=%0d: got %h expected %h",
                                         sw_nch[d], va, vb, vsub, vcin, got_s[d], exp_s);
                            end
                            checks++;
                            if (got_ovf[d] !== exp_ovf) begin
                                failures++;
                                $display("FAIL sweep_ovf nch=%0d a=%0d b=%0d sub=%0d cin=%0d: got %b expected %b",
                                         sw_nch[d], va, vb, vsub, vcin, got_ovf[d], exp_ovf);
                            end
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        sw_start = 1'b0; sw_sub = 1'b0; sw_cin = 1'b0; sw_a = '0; sw_b = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_add_carry();
        test_signed_ovf();
        test_sub_borrow();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
